// File: rtl/countdown_mmss.sv
// MM:SS BCD countdown timer with load/start/pause control and a one-cycle done pulse.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to restart from the loaded preset on expiry.
module countdown_mmss #(
  parameter int unsigned MAX_MIN_T = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] ld_val,
  input  logic        start,
  input  logic        pause,
  output logic [3:0]  sec_u,
  output logic [3:0]  sec_t,
  output logic [3:0]  min_u,
  output logic [3:0]  min_t,
  output logic        done,
  output logic        running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] MT_MAX = 4'(MAX_MIN_T);

  state_t     state_q, state_d;
  logic [3:0] sec_u_q, sec_u_d;
  logic [3:0] sec_t_q, sec_t_d;
  logic [3:0] min_u_q, min_u_d;
  logic [3:0] min_t_q, min_t_d;
  logic       done_q, done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [15:0] reload_q, reload_d;
`endif

  logic [3:0] ld_su, ld_st, ld_mu, ld_mt;
  logic [3:0] dec_su, dec_st, dec_mu, dec_mt;
  logic       cnt_zero, dec_zero;

  always_comb begin
    ld_su = (ld_val[3:0]   > 4'd9)   ? 4'd9   : ld_val[3:0];
    ld_st = (ld_val[7:4]   > 4'd5)   ? 4'd5   : ld_val[7:4];
    ld_mu = (ld_val[11:8]  > 4'd9)   ? 4'd9   : ld_val[11:8];
    ld_mt = (ld_val[15:12] > MT_MAX) ? MT_MAX : ld_val[15:12];
  end

  // Borrow chain; only evaluated when the count is known nonzero.
  always_comb begin
    dec_su = sec_u_q;
    dec_st = sec_t_q;
    dec_mu = min_u_q;
    dec_mt = min_t_q;
    if (sec_u_q != 4'd0) begin
      dec_su = sec_u_q - 4'd1;
    end else begin
      dec_su = 4'd9;
      if (sec_t_q != 4'd0) begin
        dec_st = sec_t_q - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (min_u_q != 4'd0) begin
          dec_mu = min_u_q - 4'd1;
        end else begin
          dec_mu = 4'd9;
          dec_mt = min_t_q - 4'd1;
        end
      end
    end
  end

  assign cnt_zero = ({min_t_q, min_u_q, sec_t_q, sec_u_q} == 16'h0000);
  assign dec_zero = ({dec_mt, dec_mu, dec_st, dec_su} == 16'h0000);

  always_comb begin
    state_d = state_q;
    sec_u_d = sec_u_q;
    sec_t_d = sec_t_q;
    min_u_d = min_u_q;
    min_t_d = min_t_q;
    done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (rst) begin
      state_d = IDLE;
      sec_u_d = '0;
      sec_t_d = '0;
      min_u_d = '0;
      min_t_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d = '0;
`endif
    end else if (load) begin
      state_d = IDLE;
      sec_u_d = ld_su;
      sec_t_d = ld_st;
      min_u_d = ld_mu;
      min_t_d = ld_mt;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d = {ld_mt, ld_mu, ld_st, ld_su};
`endif
    end else begin
      unique case (state_q)
        IDLE, PAUSE: begin
          if (start && !cnt_zero) state_d = RUN;
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (cnt_zero) begin
            state_d = DONE;
          end else if (tick) begin
            sec_u_d = dec_su;
            sec_t_d = dec_st;
            min_u_d = dec_mu;
            min_t_d = dec_mt;
            if (dec_zero) begin
              done_d  = 1'b1;
              state_d = DONE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (reload_q != 16'h0000) begin
                state_d = RUN;
                {min_t_d, min_u_d, sec_t_d, sec_u_d} = reload_q;
              end
`endif
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    sec_u_q <= sec_u_d;
    sec_t_q <= sec_t_d;
    min_u_q <= min_u_d;
    min_t_q <= min_t_d;
    done_q  <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_q <= reload_d;
`endif
  end

  assign sec_u   = sec_u_q;
  assign sec_t   = sec_t_q;
  assign min_u   = min_u_q;
  assign min_t   = min_t_q;
  assign done    = done_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_countdown_mmss.sv
// Bench for countdown_mmss: a seconds-based model checked every cycle plus directed literal checks.
module tb_countdown_mmss;

  localparam int unsigned MAXT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] ld_val = '0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [3:0]  sec_u, sec_t, min_u, min_t;
  logic        done, running;

  countdown_mmss #(.MAX_MIN_T(MAXT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .ld_val(ld_val),
    .start(start), .pause(pause), .sec_u(sec_u), .sec_t(sec_t),
    .min_u(min_u), .min_t(min_t), .done(done), .running(running)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int done_seen = 0;

  // Model: count kept as total seconds; state 0 idle, 1 run, 2 pause, 3 done.
  int m_secs = 0;
  int m_st = 0;
  bit m_done = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  int m_rel = 0;
`endif

  function automatic int clamp_secs(input logic [15:0] v);
    int su, st, mu, mt;
    su = int'(v[3:0]);   if (su > 9) su = 9;
    st = int'(v[7:4]);   if (st > 5) st = 5;
    mu = int'(v[11:8]);  if (mu > 9) mu = 9;
    mt = int'(v[15:12]); if (mt > int'(MAXT)) mt = int'(MAXT);
    return (mt * 10 + mu) * 60 + st * 10 + su;
  endfunction

  function automatic logic [15:0] secs_bcd(input int s);
    int m, ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_secs = 0; m_st = 0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      m_rel = 0;
`endif
    end else if (load) begin
      m_secs = clamp_secs(ld_val); m_st = 0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      m_rel = m_secs;
`endif
    end else if ((m_st == 0 || m_st == 2) && start && m_secs != 0) begin
      m_st = 1;
    end else if (m_st == 1 && pause) begin
      m_st = 2;
    end else if (m_st == 1 && tick) begin
      if (m_secs == 1) begin
        m_done = 1'b1;
        m_secs = 0;
        m_st = 3;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (m_rel != 0) begin m_secs = m_rel; m_st = 1; end
`endif
      end else begin
        m_secs = m_secs - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_seen++;
    if (chk_en) begin
      n_vec++;
      if ({min_t, min_u, sec_t, sec_u, done, running} !== {secs_bcd(m_secs), m_done, (m_st == 1)}) begin
        n_err++;
        $display("FAIL cycle t=%0t got digits=%h done=%b run=%b required digits=%h done=%b run=%b",
                 $time, {min_t, min_u, sec_t, sec_u}, done, running, secs_bcd(m_secs), m_done, (m_st == 1));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic step(input logic t, input logic ld, input logic [15:0] v,
                      input logic st, input logic pa);
    tick = t; load = ld; ld_val = v; start = st; pause = pa;
    @(posedge clk);
    #1;
    tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    step(1'b0, 1'b1, v, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  function automatic logic [15:0] digits();
    return {min_t, min_u, sec_t, sec_u};
  endfunction

  int d0;

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_digits", 32'(digits()), 32'h0000);
    check("reset_running", 32'(running), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    // 12 seconds to zero
    d0 = done_seen;
    do_load(16'h0012); do_start(); ticks(12); idle(2);
    check("r33_digits", 32'(digits()), 32'h0000);
    check("r33_done_pulses", 32'(done_seen - d0), 32'd1);
    check("r33_running", 32'(running), 32'd0);
    ticks(2);
    check("r33_done_holds", 32'(digits()), 32'h0000);

    // minute borrow
    d0 = done_seen;
    do_load(16'h0100); do_start(); ticks(1);
    check("r34_digits", 32'(digits()), 32'h0059);
    check("r34_no_done", 32'(done_seen - d0), 32'd0);

    // clamp and full hour
    do_load(16'h9F7A); #1;
    check("r35_clamp", 32'(digits()), 32'h5959);
    d0 = done_seen;
    do_start(); ticks(3600); idle(1);
    check("r35_digits", 32'(digits()), 32'h0000);
    check("r35_done_pulses", 32'(done_seen - d0), 32'd1);

    // tick+pause collision
    d0 = done_seen;
    do_load(16'h0005); do_start(); ticks(2);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    check("r36_paused", 32'(digits()), 32'h0003);
    check("r36_not_running", 32'(running), 32'd0);
    ticks(5);
    check("r36_held", 32'(digits()), 32'h0003);
    do_start(); ticks(3); idle(1);
    check("r36_done_pulses", 32'(done_seen - d0), 32'd1);

    // zero start and load+start
    d0 = done_seen;
    do_load(16'h0000); do_start(); idle(1);
    check("r37_zero_running", 32'(running), 32'd0);
    check("r37_zero_no_done", 32'(done_seen - d0), 32'd0);
    step(1'b0, 1'b1, 16'h0030, 1'b1, 1'b0);
    check("r37_ldst_running", 32'(running), 32'd0);
    check("r37_ldst_digits", 32'(digits()), 32'h0030);
    ticks(2);
    check("r37_idle_ticks", 32'(digits()), 32'h0030);

    // reset mid-run
    d0 = done_seen;
    do_start(); ticks(3);
    rst = 1'b1; idle(1); rst = 1'b0;
    idle(1);
    check("rst_mid_digits", 32'(digits()), 32'h0000);
    check("rst_mid_no_done", 32'(done_seen - d0), 32'd0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    d0 = done_seen;
    do_load(16'h0003); do_start(); ticks(7);
    check("r38_digits", 32'(digits()), 32'h0002);
    check("r38_running", 32'(running), 32'd1);
    check("r38_done_pulses", 32'(done_seen - d0), 32'd2);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_mmss.md
COUNTDOWN_MMSS -- requirements
Module: countdown_mmss

Interface
REQ-001 The block SHALL have parameter MAX_MIN_T, default 5, giving the maximum minutes-tens digit (count range 00:00 to MAX_MIN_T9:59).
REQ-002 The block SHALL have port clk, input, 1, the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have port tick, input, 1, a one-cycle count enable (one pulse per second).
REQ-005 The block SHALL have port load, input, 1, a one-cycle request to load ld_val.
REQ-006 The block SHALL have port ld_val, input, 16, the BCD preset {min_t, min_u, sec_t, sec_u}, 4 bits each.
REQ-007 The block SHALL have port start, input, 1, a one-cycle request to run or resume.
REQ-008 The block SHALL have port pause, input, 1, a one-cycle request to freeze the count.
REQ-009 The block SHALL have ports sec_u, sec_t, min_u and min_t, each output, 4, a registered BCD digit of the current count.
REQ-010 The block SHALL have port done, output, 1, a registered one-cycle pulse asserted on reaching 00:00.
REQ-011 The block SHALL have port running, output, 1, high exactly while the state is RUN.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, RUN, PAUSE and DONE.
REQ-013 load SHALL, in any state, capture the clamped ld_val into the digits and the reload register on the next edge, and enter IDLE.
- Clamping rule: sec_u and min_u values above 9 become 9; sec_t values above 5 become 5; min_t values above MAX_MIN_T become MAX_MIN_T.
REQ-014 load SHALL have priority over start, pause and tick in the same cycle.
REQ-015 start in IDLE or PAUSE SHALL enter RUN when the count is nonzero.
REQ-016 start in IDLE or PAUSE with a count of 00:00 SHALL leave the state unchanged and SHALL NOT pulse done.
REQ-017 start in RUN or DONE SHALL be ignored.
REQ-018 pause in RUN SHALL enter PAUSE; pause in any other state SHALL be ignored.
REQ-019 tick in RUN, with no pause in the same cycle, SHALL decrement the count by one second on that edge.
REQ-020 The decrement SHALL use a BCD borrow chain:
- sec_u 0 -> 9, borrowing from sec_t;
- sec_t 0 -> 5, borrowing from min_u;
- min_u 0 -> 9, borrowing from min_t;
- min_t decrements only on a borrow.
REQ-021 tick and pause in the same RUN cycle SHALL discard the tick and enter PAUSE.
REQ-022 tick in IDLE, PAUSE or DONE SHALL leave the digits unchanged.
REQ-023 A tick that moves the count from 00:01 to 00:00 SHALL cause done = 1 for exactly the cycle after that edge; the digits read 0000 in the same cycle.
REQ-024 With the count at 00:00 in RUN, the state SHALL go to DONE at the same edge (subject to REQ-031).
REQ-025 DONE SHALL be left only by load or rst.
REQ-026 done SHALL never be asserted for two consecutive cycles.
REQ-027 The count SHALL never underflow below 00:00 and SHALL never hold a non-BCD digit value.

Reset
REQ-028 rst SHALL have priority over every other input.
REQ-029 While rst is high, the block SHALL force all digits to 0, the reload register to 0, the state to IDLE, done to 0 and running to 0 on the next edge.
REQ-030 rst asserted mid-RUN SHALL abort the countdown without a done pulse.

Configuration
REQ-031 When macro COUNTDOWN_AUTO_RELOAD_EN is defined, reaching 00:00 in RUN SHALL pulse done, reload the digits from the reload register at the same edge, and stay in RUN.
- If the reload register is 0000, the block SHALL instead enter DONE.
REQ-032 When COUNTDOWN_AUTO_RELOAD_EN is undefined, the block SHALL behave per REQ-024, and the reload register SHALL be optional and unobservable.

Verification
REQ-033 The bench SHALL check: rst -> digits 0000, running 0, done 0; then load 0x0012, start, 12 ticks -> 00:00, one done pulse, state DONE, running 0.
REQ-034 The bench SHALL check: load 0x0100, start, 1 tick -> digits 0,0,5,9 (00:59), no done.
REQ-035 The bench SHALL check: load 0x9F7A -> digits clamp to 5,9,5,9 (59:59).
- Then start and 3600 ticks -> 00:00 with exactly one done pulse.
REQ-036 The bench SHALL check: load 0x0005, start, 2 ticks, then tick and pause in the same cycle -> count 00:03 held.
- Then 5 further ticks -> 00:03 held; then start and 3 ticks -> done pulse.
REQ-037 The bench SHALL check: load 0x0000, start -> state IDLE, no done; and load with start in the same cycle -> IDLE with the new value.
REQ-038 The bench SHALL check, with COUNTDOWN_AUTO_RELOAD_EN defined: load 0x0003, start, 7 ticks -> done pulses after ticks 3 and 6, count 00:02, running 1.
